// File: rtl/hls_deadlock_pkg.sv
// Shared types and helpers for the HLS dataflow deadlock monitors.
package hls_deadlock_pkg;

   typedef enum logic [1:0] {
      IDLE,
      WATCH,
      BLOCKED
   } dl_state_t;

   localparam int unsigned STALL_CNT_W = 16;

   function automatic int unsigned dl_clog2(input int unsigned value);
      int unsigned r;
      r = 0;
      while ((64'd1 << r) < 64'(value)) r++;
      return r;
   endfunction

endpackage

// File: rtl/hls_deadlock_prio_enc.sv
// Lowest-set-bit encoder; idx is 0 when vec is all zero.
module hls_deadlock_prio_enc
   import hls_deadlock_pkg::*;
#(
   parameter int unsigned N = 6,
   parameter int unsigned W = (dl_clog2(N) > 1) ? dl_clog2(N) : 1
) (
   input  logic [N-1:0] vec,
   output logic [W-1:0] idx
);

   logic found;

   always_comb begin
      idx   = '0;
      found = 1'b0;
      for (int unsigned i = 0; i < N; i++) begin
         if (vec[i] && !found) begin
            idx   = W'(i);
            found = 1'b1;
         end
      end
   end

endmodule

// File: rtl/hls_deadlock_persist_monitor.sv
// Deadlock monitor: a stall candidate must persist PERSIST_CYCLES edges before block is raised.
module hls_deadlock_persist_monitor
   import hls_deadlock_pkg::*;
#(
   parameter int unsigned NUM_AXIS       = 2,
   parameter int unsigned NUM_INST       = 4,
   parameter int unsigned PERSIST_CYCLES = 16,
   parameter int unsigned STICKY         = 1,
   localparam int unsigned NUM_SRC = NUM_AXIS + NUM_INST,
   localparam int unsigned SRC_W   = (dl_clog2(NUM_SRC) > 1) ? dl_clog2(NUM_SRC) : 1,
   localparam int unsigned CNT_W   = dl_clog2(PERSIST_CYCLES + 1)
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   clear,
   input  logic [NUM_AXIS-1:0]    axis_mask,
   input  logic [NUM_AXIS-1:0]    axis_block_sigs,
   input  logic [NUM_INST-1:0]    inst_idle_sigs,
   input  logic [NUM_INST-1:0]    inst_block_sigs,
   output logic                   block,
   output logic [SRC_W-1:0]       first_idx,
   output logic [STALL_CNT_W-1:0] stall_cnt
);

   localparam logic [CNT_W-1:0] PCNT_LAST = CNT_W'(PERSIST_CYCLES - 1);

   dl_state_t              state, state_nxt;
   logic [CNT_W-1:0]       pcnt, pcnt_nxt;
   logic                   block_nxt;
   logic [SRC_W-1:0]       idx_nxt;
   logic [STALL_CNT_W-1:0] stall_nxt;
   logic [NUM_SRC-1:0]     src;
   logic [SRC_W-1:0]       lead;
   logic                   cand;

   // Idle instances are never treated as blocked.
   assign src  = {inst_block_sigs & ~inst_idle_sigs, axis_block_sigs & axis_mask};
   assign cand = |src;

   hls_deadlock_prio_enc #(
      .N (NUM_SRC),
      .W (SRC_W)
   ) u_prio_enc (
      .vec (src),
      .idx (lead)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         pcnt      <= '0;
         block     <= 1'b0;
         first_idx <= '0;
         stall_cnt <= '0;
      end else begin
         state     <= state_nxt;
         pcnt      <= pcnt_nxt;
         block     <= block_nxt;
         first_idx <= idx_nxt;
         stall_cnt <= stall_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      pcnt_nxt  = pcnt;
      block_nxt = block;
      idx_nxt   = first_idx;
      stall_nxt = stall_cnt;
      if (clear) begin
         state_nxt = IDLE;
         pcnt_nxt  = '0;
         block_nxt = 1'b0;
         idx_nxt   = '0;
         stall_nxt = '0;
      end else begin
         case (state)
            IDLE: begin
               if (cand) begin
                  idx_nxt   = lead;
                  stall_nxt = '0;
                  if (PERSIST_CYCLES == 1) begin
                     state_nxt = BLOCKED;
                     block_nxt = 1'b1;
                  end else begin
                     state_nxt = WATCH;
                     pcnt_nxt  = CNT_W'(1);
                  end
               end
            end
            WATCH: begin
               if (!cand) begin
                  state_nxt = IDLE;
                  pcnt_nxt  = '0;
               end else if (pcnt == PCNT_LAST) begin
                  state_nxt = BLOCKED;
                  block_nxt = 1'b1;
                  pcnt_nxt  = '0;
               end else begin
                  pcnt_nxt = pcnt + CNT_W'(1);
               end
            end
            BLOCKED: begin
               if (STICKY == 0 && !cand) begin
                  state_nxt = IDLE;
                  block_nxt = 1'b0;
               end else if (stall_cnt != '1) begin
                  stall_nxt = stall_cnt + STALL_CNT_W'(1);
               end
            end
            default: begin
               state_nxt = IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_hls_deadlock_persist_monitor.sv
// Directed bench for hls_deadlock_persist_monitor across three parameter sets sharing one stimulus.
module tb_hls_deadlock_persist_monitor;

   logic        clock = 1'b0;
   logic        reset;
   logic        clear_ac;
   logic        clear_b;
   logic [1:0]  axis_mask;
   logic [1:0]  axis_blk;
   logic [3:0]  inst_idle;
   logic [3:0]  inst_blk;

   logic        block_a, block_b, block_c;
   logic [2:0]  fidx_a, fidx_b, fidx_c;
   logic [15:0] stall_a, stall_b, stall_c;

   int unsigned vectors    = 0;
   int unsigned miscompares = 0;

   always #5 clock = ~clock;

   // a: filtered, non-sticky
   hls_deadlock_persist_monitor #(
      .NUM_AXIS (2), .NUM_INST (4), .PERSIST_CYCLES (4), .STICKY (0)
   ) dut_a (
      .clock (clock), .reset (reset), .clear (clear_ac),
      .axis_mask (axis_mask), .axis_block_sigs (axis_blk),
      .inst_idle_sigs (inst_idle), .inst_block_sigs (inst_blk),
      .block (block_a), .first_idx (fidx_a), .stall_cnt (stall_a)
   );

   // b: filtered, sticky
   hls_deadlock_persist_monitor #(
      .NUM_AXIS (2), .NUM_INST (4), .PERSIST_CYCLES (4), .STICKY (1)
   ) dut_b (
      .clock (clock), .reset (reset), .clear (clear_b),
      .axis_mask (axis_mask), .axis_block_sigs (axis_blk),
      .inst_idle_sigs (inst_idle), .inst_block_sigs (inst_blk),
      .block (block_b), .first_idx (fidx_b), .stall_cnt (stall_b)
   );

   // c: single-register legacy behaviour
   hls_deadlock_persist_monitor #(
      .NUM_AXIS (2), .NUM_INST (4), .PERSIST_CYCLES (1), .STICKY (0)
   ) dut_c (
      .clock (clock), .reset (reset), .clear (clear_ac),
      .axis_mask (axis_mask), .axis_block_sigs (axis_blk),
      .inst_idle_sigs (inst_idle), .inst_block_sigs (inst_blk),
      .block (block_c), .first_idx (fidx_c), .stall_cnt (stall_c)
   );

   task automatic tick(input int unsigned n);
      for (int unsigned i = 0; i < n; i++) begin
         @(posedge clock);
         #1;
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [2:0] lowest(input logic [5:0] v);
      logic [2:0] r;
      r = 3'd0;
      for (int i = 5; i >= 0; i--) if (v[i]) r = 3'(i);
      return r;
   endfunction

   logic [5:0] src_m;
   logic       cand_m;
   logic       mblk;
   logic [2:0] midx;

   initial begin
      reset     = 1'b1;
      clear_ac  = 1'b0;
      clear_b   = 1'b1;
      axis_mask = 2'b11;
      axis_blk  = 2'b00;
      inst_idle = 4'h0;
      inst_blk  = 4'h0;
      tick(2);
      reset = 1'b0;
      chk("reset_block", 32'(block_a), 32'd0);
      chk("reset_fidx", 32'(fidx_a), 32'd0);
      chk("reset_stall", 32'(stall_a), 32'd0);
      tick(1);

      // short burst on stream 1 is filtered
      axis_blk = 2'b10;
      tick(3);
      chk("burst3_block", 32'(block_a), 32'd0);
      chk("burst3_fidx", 32'(fidx_a), 32'd1);
      axis_blk = 2'b00;
      tick(1);
      chk("burst_drop_block", 32'(block_a), 32'd0);
      chk("burst_drop_fidx_held", 32'(fidx_a), 32'd1);

      // sustained stall on stream 0
      axis_blk = 2'b01;
      tick(3);
      chk("hold_edge3_block", 32'(block_a), 32'd0);
      tick(1);
      chk("hold_edge4_block", 32'(block_a), 32'd1);
      chk("hold_edge4_fidx", 32'(fidx_a), 32'd0);
      chk("hold_edge4_stall", 32'(stall_a), 32'd0);
      tick(2);
      chk("hold_edge6_stall", 32'(stall_a), 32'd2);
      axis_blk = 2'b00;
      #1;
      chk("no_comb_path", 32'(block_a), 32'd1);
      tick(1);
      chk("release_block", 32'(block_a), 32'd0);

      // one low sample restarts the window
      axis_blk = 2'b01;
      tick(2);
      axis_blk = 2'b00;
      tick(1);
      axis_blk = 2'b01;
      tick(3);
      chk("restart_edge3_block", 32'(block_a), 32'd0);
      tick(1);
      chk("restart_edge4_block", 32'(block_a), 32'd1);
      axis_blk = 2'b00;
      tick(1);

      // idle instance never counts as blocked
      inst_blk  = 4'b0100;
      inst_idle = 4'b0100;
      tick(5);
      chk("idle_inst_block", 32'(block_a), 32'd0);
      inst_idle = 4'b0000;
      tick(3);
      chk("inst_edge3_block", 32'(block_a), 32'd0);
      tick(1);
      chk("inst_edge4_block", 32'(block_a), 32'd1);
      chk("inst_edge4_fidx", 32'(fidx_a), 32'd4);
      inst_blk = 4'b0000;
      tick(1);
      chk("inst_release", 32'(block_a), 32'd0);

      // sticky behaviour and clear
      clear_b  = 1'b0;
      axis_blk = 2'b10;
      tick(4);
      chk("sticky_flag", 32'(block_b), 32'd1);
      chk("sticky_fidx", 32'(fidx_b), 32'd1);
      chk("sticky_stall0", 32'(stall_b), 32'd0);
      axis_blk = 2'b00;
      tick(3);
      chk("sticky_hold", 32'(block_b), 32'd1);
      chk("sticky_stall3", 32'(stall_b), 32'd3);
      axis_blk = 2'b10;
      clear_b  = 1'b1;
      tick(1);
      chk("clear_block", 32'(block_b), 32'd0);
      chk("clear_stall", 32'(stall_b), 32'd0);
      chk("clear_fidx", 32'(fidx_b), 32'd0);
      clear_b = 1'b0;
      tick(3);
      chk("reflag_edge3", 32'(block_b), 32'd0);
      tick(1);
      chk("reflag_edge4", 32'(block_b), 32'd1);
      chk("reflag_fidx", 32'(fidx_b), 32'd1);
      axis_blk = 2'b00;
      clear_b  = 1'b1;
      tick(1);

      // masking
      axis_mask = 2'b00;
      axis_blk  = 2'b11;
      tick(20);
      chk("masked_block", 32'(block_a), 32'd0);
      axis_mask = 2'b10;
      tick(3);
      chk("unmask_edge3", 32'(block_a), 32'd0);
      tick(1);
      chk("unmask_edge4", 32'(block_a), 32'd1);
      chk("unmask_fidx", 32'(fidx_a), 32'd1);
      axis_mask = 2'b11;
      axis_blk  = 2'b00;
      clear_ac  = 1'b1;
      tick(1);
      clear_ac = 1'b0;
      mblk = 1'b0;
      midx = 3'd0;

      // legacy single-cycle monitor under random stimulus
      for (int i = 0; i < 200; i++) begin
         if ($urandom_range(0, 2) == 0) begin
            axis_blk = 2'b00;
            inst_blk = 4'h0;
         end else begin
            axis_blk = 2'($urandom);
            inst_blk = 4'($urandom);
         end
         axis_mask = 2'($urandom);
         inst_idle = 4'($urandom);
         src_m  = {inst_blk & ~inst_idle, axis_blk & axis_mask};
         cand_m = |src_m;
         tick(1);
         if (cand_m && !mblk) midx = lowest(src_m);
         mblk = cand_m;
         chk("rand_block", 32'(block_c), 32'(mblk));
         chk("rand_fidx", 32'(fidx_c), 32'(midx));
      end

      // asynchronous reset mid-stall
      axis_mask = 2'b11;
      axis_blk  = 2'b10;
      inst_blk  = 4'h0;
      inst_idle = 4'h0;
      clear_ac  = 1'b1;
      tick(1);
      clear_ac = 1'b0;
      tick(6);
      chk("pre_reset_block", 32'(block_a), 32'd1);
      chk("pre_reset_stall", 32'(stall_a), 32'd2);
      #2;
      reset = 1'b1;
      #1;
      chk("async_rst_block_a", 32'(block_a), 32'd0);
      chk("async_rst_fidx_a", 32'(fidx_a), 32'd0);
      chk("async_rst_stall_a", 32'(stall_a), 32'd0);
      chk("async_rst_block_c", 32'(block_c), 32'd0);
      chk("async_rst_fidx_c", 32'(fidx_c), 32'd0);
      tick(1);
      reset = 1'b0;
      tick(1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
